// File: rtl/sm83_irq_ctl.sv
// SM83 interrupt controller: IF/IE registers, edge-posted requests, one-hot ack retire,
// and a memory-mapped read/write responder for both registers.
module sm83_irq_ctl #(
    parameter logic [15:0] IF_ADR  = 16'hFF0F,
    parameter logic [15:0] IE_ADR  = 16'hFFFF,
    parameter int unsigned NUM_SRC = 5
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [15:0]        adr,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               dout_oe,
    input  logic               rd,
    input  logic               wr,
    input  logic [NUM_SRC-1:0] src,
    output logic [7:0]         irq,
    input  logic [7:0]         iack,
    output logic               pending
);

    logic [NUM_SRC-1:0] if_q, if_d;
    logic [7:0]         ie_q, ie_d;
    logic [NUM_SRC-1:0] src_q;
    logic               wr_q, rd_q;
    logic [7:0]         rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic               hit_if, hit_ie, hit;
    logic               wr_fire, rd_fire;
    logic [NUM_SRC-1:0] src_rise;
    logic [7:0]         if_view;

    always_comb begin
        hit_if   = (adr == IF_ADR);
        hit_ie   = (adr == IE_ADR);
        hit      = hit_if | hit_ie;
        wr_fire  = wr & ~wr_q & hit;
        rd_fire  = rd & ~rd_q & hit;
        src_rise = src & ~src_q;
        // Unimplemented IF bits read back as 1.
        if_view                = '1;
        if_view[NUM_SRC-1:0]   = if_q;
    end

    always_comb begin
        if (wr_fire && hit_if) begin
            if_d = din[NUM_SRC-1:0] | src_rise;
        end else begin
            if_d = (if_q & ~iack[NUM_SRC-1:0]) | src_rise;
        end
        ie_d = (wr_fire && hit_ie) ? din : ie_q;
    end

    // The read window stays open only while rd is held on a hit address.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q & rd & hit;
        if (rd_fire) begin
            rdata_d  = hit_if ? if_view : ie_q;
            rvalid_d = 1'b1;
        end
    end

    always_comb begin
        irq                = '0;
        irq[NUM_SRC-1:0]   = if_q & ie_q[NUM_SRC-1:0];
        pending            = |irq;
        dout_oe            = rvalid_q & rd & hit;
        dout               = dout_oe ? rdata_q : 8'hFF;
    end

    generate
        if (NUM_SRC < 8) begin : g_ack_pad
            logic unused_iack_hi;
            assign unused_iack_hi = ^iack[7:NUM_SRC];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            if_q     <= '0;
            ie_q     <= '0;
            rdata_q  <= '1;
            rvalid_q <= 1'b0;
        end else begin
            if_q     <= if_d;
            ie_q     <= ie_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
        src_q <= src;
        wr_q  <= wr;
        rd_q  <= rd;
    end

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Scoreboard bench for sm83_irq_ctl: a behavioural model predicts post-edge outputs,
// a monitor compares them against the DUT every cycle.
module tb_sm83_irq_ctl;

    localparam logic [15:0] IF_A = 16'hFF0F;
    localparam logic [15:0] IE_A = 16'hFFFF;
    localparam int          NS   = 5;
    localparam int          MASK = (1 << NS) - 1;

    logic          clk;
    logic          n_reset;
    logic [15:0]   adr;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          dout_oe;
    logic          rd;
    logic          wr;
    logic [NS-1:0] src;
    logic [7:0]    irq;
    logic [7:0]    iack;
    logic          pending;

    sm83_irq_ctl #(
        .IF_ADR (IF_A),
        .IE_ADR (IE_A),
        .NUM_SRC(NS)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .adr    (adr),
        .din    (din),
        .dout   (dout),
        .dout_oe(dout_oe),
        .rd     (rd),
        .wr     (wr),
        .src    (src),
        .irq    (irq),
        .iack   (iack),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] irq;
        logic       pend;
        logic       oe;
        logic [7:0] dout;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   started = 0;

    // Reference model state: register contents, previous strobe/line levels, open read.
    int m_if, m_ie, m_src_prev, m_cap;
    bit m_wr_prev, m_rd_prev, m_open;

    task automatic model_and_push();
        exp_t e;
        bit   is_if, is_ie, is_hit;
        int   old_if, old_ie, rises, masked;
        if (!n_reset) begin
            m_if       = 0;
            m_ie       = 0;
            m_src_prev = int'(src);
            m_wr_prev  = wr;
            m_rd_prev  = rd;
            m_open     = 0;
            m_cap      = 255;
        end else begin
            is_if  = (adr == IF_A);
            is_ie  = (adr == IE_A);
            is_hit = is_if || is_ie;
            old_if = m_if;
            old_ie = m_ie;
            rises  = int'(src) & ~m_src_prev & MASK;
            if (wr && !m_wr_prev && is_if) m_if = int'(din) & MASK;
            else                           m_if = m_if & ~(int'(iack) & MASK);
            m_if = m_if | rises;
            if (wr && !m_wr_prev && is_ie) m_ie = int'(din);
            if (rd && !m_rd_prev && is_hit) begin
                m_cap  = is_if ? ((old_if | ~MASK) & 255) : old_ie;
                m_open = 1;
            end else if (!(rd && is_hit)) begin
                m_open = 0;
            end
            m_src_prev = int'(src);
            m_wr_prev  = wr;
            m_rd_prev  = rd;
        end
        masked = m_if & m_ie & MASK;
        e.irq  = 8'(masked);
        e.pend = (masked != 0);
        e.oe   = m_open && rd && ((adr == IF_A) || (adr == IE_A));
        e.dout = e.oe ? 8'(m_cap) : 8'hFF;
        sb.push_back(e);
    endtask

    task automatic drive(input bit nr, input logic [15:0] a, input logic [7:0] d,
                         input bit r, input bit w, input logic [NS-1:0] s, input logic [7:0] ak);
        @(negedge clk);
        n_reset = nr;
        adr     = a;
        din     = d;
        rd      = r;
        wr      = w;
        src     = s;
        iack    = ak;
        started = 1;
        model_and_push();
    endtask

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s got=%02h exp=%02h t=%0t", name, act, exp_v, $time);
        end
    endfunction

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (started) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_empty got=0 exp=1 t=%0t", $time);
            end else begin
                e = sb.pop_front();
                check("irq", irq, e.irq);
                check("pending", {7'd0, pending}, {7'd0, e.pend});
                check("dout_oe", {7'd0, dout_oe}, {7'd0, e.oe});
                check("dout", dout, e.dout);
            end
        end
    end

    initial begin
        logic [15:0]   ra;
        logic [NS-1:0] rs;
        bit            rr, rw;
        n_reset = 1'b0;
        adr     = '0;
        din     = '0;
        rd      = 1'b0;
        wr      = 1'b0;
        src     = 5'h1F;
        iack    = '0;

        // Reset with all sources high; no request may post afterwards.
        drive(0, 16'h0, 8'h00, 0, 0, 5'h1F, 8'h00);
        drive(0, 16'h0, 8'h00, 0, 0, 5'h1F, 8'h00);
        drive(1, IF_A, 8'h00, 1, 0, 5'h1F, 8'h00);
        drive(1, IF_A, 8'h00, 1, 0, 5'h1F, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h1F, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);

        // Single request and ack.
        drive(1, IE_A, 8'h04, 0, 1, 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h04, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h04);
        drive(1, IF_A, 8'h00, 1, 0, 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);

        // Request beats ack, then request beats a write.
        drive(1, 16'h0, 8'h00, 0, 0, 5'h01, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h01, 8'h01);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);
        drive(1, IF_A, 8'h00, 0, 1, 5'h01, 8'h00);
        drive(1, IF_A, 8'h00, 1, 0, 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);

        // Masking, including IE bits above the implemented sources.
        drive(1, IF_A, 8'h1F, 0, 1, 5'h00, 8'h00);
        drive(1, IE_A, 8'hE0, 0, 0, 5'h00, 8'h00);
        drive(1, IE_A, 8'hE0, 0, 1, 5'h00, 8'h00);
        drive(1, IE_A, 8'h00, 1, 0, 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);
        drive(1, IE_A, 8'hFF, 0, 1, 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);

        // Held write stores only its first value; held read is stable across a request.
        for (int i = 0; i < 4; i++) drive(1, IF_A, 8'(2 + i * 7), 0, 1, 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);
        for (int i = 0; i < 4; i++) drive(1, IF_A, 8'h00, 1, 0, (i >= 2) ? 5'h08 : 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);

        // Near-miss addresses.
        drive(1, 16'hFF0E, 8'h00, 1, 0, 5'h00, 8'h00);
        drive(1, 16'hFFFE, 8'h55, 0, 1, 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);
        drive(1, IF_A, 8'h00, 1, 0, 5'h00, 8'h00);
        drive(1, IE_A, 8'h00, 1, 0, 5'h00, 8'h00);
        drive(1, 16'h0, 8'h00, 0, 0, 5'h00, 8'h00);

        // Randomized traffic.
        ra = IF_A; rs = '0; rr = 0; rw = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] ak;
            if (($urandom % 3) != 0 || !(rr || rw)) begin
                case ($urandom % 5)
                    0: ra = IF_A;
                    1: ra = IE_A;
                    2: ra = 16'hFF0E;
                    3: ra = 16'hFFFE;
                    default: ra = 16'($urandom);
                endcase
            end
            if (($urandom % 4) == 0) rr = (($urandom % 3) == 0);
            if (($urandom % 4) == 0) rw = (($urandom % 3) == 0);
            for (int b = 0; b < NS; b++) if (($urandom % 8) == 0) rs[b] = ~rs[b];
            if (($urandom % 6) == 0)       ak = 8'(1 << ($urandom % 8));
            else if (($urandom % 20) == 0) ak = 8'($urandom);
            else                           ak = 8'h00;
            drive(($urandom % 200) != 0, ra, 8'($urandom), rr, rw, rs, ak);
        end

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
